// File: rtl/apb_pkg.sv
// apb_pkg: shared APB master state type and bus/memory sizes
package apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} apb_mst_state_t;
    localparam int APB_AW = 32;
    localparam int APB_DW = 32;
    localparam int APB_MEM_DEPTH = 32;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past the last grant
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] idx;

    // Walk the offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        idx = '0;
        gnt_idx_o = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(last_grant_i) + k) % NUM_REQ);
            if (req_i[idx]) gnt_idx_o = idx;
        end
        gnt_o = (|req_i) ? NUM_REQ'(1) << gnt_idx_o : '0;
    end
endmodule

// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin APB master sharing one completer among NUM_REQ requesters
module apb_rr_master
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*APB_AW-1:0] req_addr,
    input  logic [NUM_REQ*APB_DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [APB_DW-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [APB_AW-1:0]         paddr,
    output logic [APB_DW-1:0]         pwdata,
    input  logic [APB_DW-1:0]         prdata,
    input  logic                      pready,
    input  logic                      pslverr
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    apb_mst_state_t     state_q, state_d;
    logic [IW-1:0]      last_q, last_d, gidx_q, gidx_d, arb_idx;
    logic [NUM_REQ-1:0] gnt_q, gnt_d, arb_gnt;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               pwrite_q, pwrite_d, err_q, err_d, sel_write;
    logic [APB_AW-1:0]  paddr_q, paddr_d, sel_addr;
    logic [APB_DW-1:0]  pwdata_q, pwdata_d, rdata_q, rdata_d, sel_wdata;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i       (req),
        .last_grant_i(last_q),
        .gnt_o       (arb_gnt),
        .gnt_idx_o   (arb_idx)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (arb_idx == IW'(i)) begin
                sel_write = req_write[i];
                sel_addr = req_addr[i*APB_AW +: APB_AW];
                sel_wdata = req_wdata[i*APB_DW +: APB_DW];
            end
    end

    always_comb begin
        state_d = state_q;
        last_d = last_q;
        gidx_d = gidx_q;
        gnt_d = gnt_q;
        cnt_d = cnt_q;
        pwrite_d = pwrite_q;
        paddr_d = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d = rdata_q;
        err_d = err_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d = SETUP;
                gidx_d = arb_idx;
                gnt_d = arb_gnt;
                pwrite_d = sel_write;
                paddr_d = sel_addr;
                pwdata_d = sel_wdata;
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d = '0;
            end
            // pready wins over the timeout on the final wait cycle.
            ACCESS: if (pready) begin
                state_d = DONE;
                rdata_d = pwrite_q ? '0 : prdata;
                err_d = pslverr;
            end else if (cnt_q == CW'(TIMEOUT)) begin
                state_d = DONE;
                rdata_d = '0;
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                last_d = gidx_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            last_q <= IW'(NUM_REQ - 1);
            gidx_q <= '0;
            gnt_q <= '0;
            cnt_q <= '0;
            pwrite_q <= 1'b0;
            paddr_q <= '0;
            pwdata_q <= '0;
            rdata_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            gidx_q <= gidx_d;
            gnt_q <= gnt_d;
            cnt_q <= cnt_d;
            pwrite_q <= pwrite_d;
            paddr_q <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q <= rdata_d;
            err_q <= err_d;
        end
    end

    assign psel = (state_q == SETUP) || (state_q == ACCESS);
    assign penable = state_q == ACCESS;
    assign ack = (state_q == DONE) ? gnt_q : '0;
    assign pwrite = pwrite_q;
    assign paddr = paddr_q;
    assign pwdata = pwdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err = err_q;
endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: randomized bench with an APB word-memory completer and a round-robin reference model
module tb_apb_rr_master;
    import apb_pkg::*;
    localparam int N = 4;
    localparam int TO = 4;

    logic          pclk = 1'b0;
    logic          preset;
    logic [N-1:0]  req;
    logic [N-1:0]  req_write;
    logic [N*32-1:0] req_addr, req_wdata;
    logic [N-1:0]  ack;
    logic [31:0]   rsp_rdata, paddr, pwdata, prdata;
    logic          rsp_err, psel, penable, pwrite, pready, pslverr;

    int vectors = 0;
    int miscompares = 0;

    bit          wr_arr [N] = '{default: 1'b0};
    logic [31:0] a_arr [N] = '{default: 32'h0};
    logic [31:0] d_arr [N] = '{default: 32'h0};

    for (genvar g = 0; g < N; g++) begin : g_drv
        assign req_write[g] = wr_arr[g];
        assign req_addr[g*32 +: 32] = a_arr[g];
        assign req_wdata[g*32 +: 32] = d_arr[g];
    end

    apb_rr_master #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .pclk(pclk), .preset(preset), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // Memory completer: wait_n wait states, stall holds pready low, rdy_always drives pready everywhere.
    logic [31:0] mem [APB_MEM_DEPTH] = '{default: 32'h0};
    int acc_cnt = 0;
    int wait_n = 0;
    bit stall = 1'b0;
    bit rdy_always = 1'b0;
    logic in_range;
    assign in_range = paddr < 32'(APB_MEM_DEPTH);
    assign pready = rdy_always || (psel && penable && !stall && acc_cnt >= wait_n);
    assign prdata = (psel && in_range) ? mem[paddr[4:0]] : 32'h0;
    assign pslverr = psel && penable && !in_range;
    always @(posedge pclk) begin
        acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
        if (psel && penable && pready && pwrite && in_range) mem[paddr[4:0]] <= pwdata;
    end

    logic [31:0] ref_mem [APB_MEM_DEPTH] = '{default: 32'h0};
    int m_last = N - 1;
    bit          b_w [N];
    logic [31:0] b_a [N];
    logic [31:0] b_d [N];
    logic [N-1:0] obs_ack [$];
    logic [31:0]  obs_rd [$];
    logic         obs_er [$];
    logic         obs_ps [$];

    function automatic int rr_pick(logic [N-1:0] pend, int last);
        for (int k = 1; k <= N; k++)
            if (((pend >> ((last + k) % N)) & N'(1)) != '0) return (last + k) % N;
        return 0;
    endfunction

    function automatic int eff_wait();
        return stall ? TO + 1 : (rdy_always ? 0 : wait_n);
    endfunction

    function automatic void model_apply(input bit w, input logic [31:0] a, input logic [31:0] d,
                                        input int waits, output logic [31:0] rd, output logic er);
        rd = 32'h0;
        er = 1'b1;
        if (waits <= TO && a < 32'(APB_MEM_DEPTH)) begin
            er = 1'b0;
            if (w) ref_mem[a[4:0]] = d;
            else rd = ref_mem[a[4:0]];
        end
    endfunction

    task automatic xfer(input int r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [N-1:0] ack_v, output logic [31:0] rd,
                        output logic er, output logic ps, output bit ph_ok);
        lat = 0;
        ph_ok = 1'b1;
        @(posedge pclk); #1;
        wr_arr[r] = w; a_arr[r] = a; d_arr[r] = d;
        req = req | (N'(1) << r);
        do begin
            @(posedge pclk); #1;
            lat++;
            if (lat == 1) begin
                ph_ok &= psel && !penable && paddr == a && pwrite == w && (!w || pwdata == d);
                wr_arr[r] = !w; a_arr[r] = ~a; d_arr[r] = ~d;
            end else if (ack == '0) begin
                ph_ok &= psel && penable && paddr == a && pwrite == w && (!w || pwdata == d);
            end
        end while (ack == '0 && lat < 20);
        ack_v = ack; rd = rsp_rdata; er = rsp_err; ps = psel;
        req = req & ~(N'(1) << r);
    endtask

    task automatic run_batch(input logic [N-1:0] mask);
        obs_ack.delete(); obs_rd.delete(); obs_er.delete(); obs_ps.delete();
        for (int i = 0; i < N; i++)
            if (mask[i]) begin
                wr_arr[i] = b_w[i]; a_arr[i] = b_a[i]; d_arr[i] = b_d[i];
            end
        req = req | mask;
        for (int c = 0; c < 40 * N && req != '0; c++) begin
            @(posedge pclk); #1;
            if (ack != '0) begin
                obs_ack.push_back(ack); obs_rd.push_back(rsp_rdata);
                obs_er.push_back(rsp_err); obs_ps.push_back(psel);
                req = req & ~ack;
            end
        end
    endtask

    task automatic test_reset();
        preset = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        vectors++;
        if ({psel, penable, pwrite} !== 3'b000 || paddr !== 32'h0 || pwdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_bus: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h, want all 0",
                     psel, penable, pwrite, paddr, pwdata);
        end
        vectors++;
        if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || ack !== '0) begin
            miscompares++;
            $display("FAIL reset_rsp: rdata=%h err=%b ack=%b, want 0 0 0", rsp_rdata, rsp_err, ack);
        end
        preset = 1'b0;
        m_last = N - 1;
    endtask

    task automatic test_contention();
        logic [N-1:0] pend;
        int p;
        logic [31:0] erd;
        logic eer;
        stall = 1'b0; wait_n = 0; rdy_always = 1'b0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < N; i++) begin
                b_w[i] = (ph == 0);
                b_a[i] = 32'(i);
                if (ph == 0) b_d[i] = 32'hA500_0000 | (32'(i) << 16) | ($urandom & 32'hFFFF);
            end
            run_batch({N{1'b1}});
            pend = '1;
            for (int k = 0; k < N; k++) begin
                p = rr_pick(pend, m_last);
                model_apply(b_w[p], b_a[p], b_d[p], eff_wait(), erd, eer);
                vectors++;
                if (k >= obs_ack.size() || obs_ack[k] !== N'(1) << p || obs_rd[k] !== erd ||
                    obs_er[k] !== eer || obs_ps[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL contention ph%0d slot%0d: got %0d acks, want ack=%b rdata=%h err=%b psel=0",
                             ph, k, obs_ack.size(), N'(1) << p, erd, eer);
                end
                m_last = p;
                pend = pend & ~(N'(1) << p);
            end
            vectors++;
            if (obs_ack.size() != N) begin
                miscompares++;
                $display("FAIL contention_count ph%0d: acks=%0d, want %0d", ph, obs_ack.size(), N);
            end
        end
    endtask

    task automatic test_write_read();
        int lat;
        logic [N-1:0] av;
        logic [31:0] rd;
        logic er, ps;
        bit ok;
        xfer(2, 1'b1, 32'd5, 32'hDEADBEEF, lat, av, rd, er, ps, ok);
        ref_mem[5] = 32'hDEADBEEF;
        m_last = 2;
        vectors++;
        if (av !== 4'b0100 || lat != 3 || er !== 1'b0 || rd !== 32'h0 || ps !== 1'b0 || !ok) begin
            miscompares++;
            $display("FAIL write: ack=%b lat=%0d rdata=%h err=%b psel=%b phases=%b, want 0100 3 0 0 0 1",
                     av, lat, rd, er, ps, ok);
        end
        xfer(2, 1'b0, 32'd5, 32'h0, lat, av, rd, er, ps, ok);
        vectors++;
        if (av !== 4'b0100 || lat != 3 || rd !== 32'hDEADBEEF || er !== 1'b0 || !ok) begin
            miscompares++;
            $display("FAIL read: ack=%b lat=%0d rdata=%h err=%b phases=%b, want 0100 3 deadbeef 0 1",
                     av, lat, rd, er, ok);
        end
        wait_n = 2;
        xfer(2, 1'b0, 32'd5, 32'h0, lat, av, rd, er, ps, ok);
        wait_n = 0;
        vectors++;
        if (av !== 4'b0100 || lat != 5 || rd !== 32'hDEADBEEF || er !== 1'b0 || !ok) begin
            miscompares++;
            $display("FAIL read_wait2: ack=%b lat=%0d rdata=%h err=%b phases=%b, want 0100 5 deadbeef 0 1",
                     av, lat, rd, er, ok);
        end
    endtask

    task automatic test_slverr();
        int lat;
        logic [N-1:0] av;
        logic [31:0] rd;
        logic er, ps;
        bit ok;
        xfer(1, 1'b0, 32'd40, 32'h0, lat, av, rd, er, ps, ok);
        m_last = 1;
        vectors++;
        if (av !== 4'b0010 || lat != 3 || er !== 1'b1 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL slverr: ack=%b lat=%0d rdata=%h err=%b, want 0010 3 0 1", av, lat, rd, er);
        end
    endtask

    task automatic test_timeout();
        int lat;
        logic [N-1:0] av;
        logic [31:0] rd;
        logic er, ps;
        bit ok;
        wait_n = TO;
        xfer(3, 1'b0, 32'd5, 32'h0, lat, av, rd, er, ps, ok);
        m_last = 3;
        vectors++;
        if (av !== 4'b1000 || lat != TO + 3 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            miscompares++;
            $display("FAIL last_wait: ack=%b lat=%0d rdata=%h err=%b, want 1000 %0d deadbeef 0",
                     av, lat, rd, er, TO + 3);
        end
        stall = 1'b1;
        xfer(3, 1'b0, 32'd5, 32'h0, lat, av, rd, er, ps, ok);
        vectors++;
        if (av !== 4'b1000 || lat != TO + 3 || rd !== 32'h0 || er !== 1'b1 || ps !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_rd: ack=%b lat=%0d rdata=%h err=%b psel=%b, want 1000 %0d 0 1 0",
                     av, lat, rd, er, ps, TO + 3);
        end
        xfer(0, 1'b1, 32'd6, 32'h1234_5678, lat, av, rd, er, ps, ok);
        m_last = 0;
        vectors++;
        if (av !== 4'b0001 || lat != TO + 3 || er !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_wr: ack=%b lat=%0d err=%b, want 0001 %0d 1", av, lat, er, TO + 3);
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        @(posedge pclk); #1;
        wr_arr[2] = 1'b1; a_arr[2] = 32'd9; d_arr[2] = 32'h0BAD_F00D;
        req = req | 4'b0100;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(posedge pclk); #1;
            hit = penable;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL reach_access: penable=%b, want 1 within 10 cycles", penable);
        end
        preset = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0;
        vectors++;
        if (psel !== 1'b0 || penable !== 1'b0 || ack !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: psel=%b penable=%b ack=%b, want 0 0 0", psel, penable, ack);
        end
        m_last = N - 1;
        stall = 1'b0;
        wait_n = 0;
        b_w[0] = 1'b0; b_a[0] = 32'd5; b_d[0] = 32'h0;
        b_w[2] = 1'b0; b_a[2] = 32'd9; b_d[2] = 32'h0;
        run_batch(4'b0101);
        vectors++;
        if (obs_ack.size() != 2 || obs_ack[0] !== 4'b0001 || obs_rd[0] !== ref_mem[5] || obs_er[0] !== 1'b0 ||
            obs_ack[1] !== 4'b0100 || obs_rd[1] !== ref_mem[9] || obs_er[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset: acks=%0d, want 2 acks 0001 (rdata %h) then 0100 (rdata %h), no err",
                     obs_ack.size(), ref_mem[5], ref_mem[9]);
        end
        m_last = 2;
    endtask

    task automatic test_random();
        logic [N-1:0] mask, pend;
        int p, n;
        logic [31:0] erd;
        logic eer;
        for (int it = 0; it < 40; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                b_w[i] = 1'($urandom);
                b_a[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(32, 63)) : 32'($urandom_range(0, 31));
                b_d[i] = $urandom;
            end
            stall = 1'b0;
            wait_n = $urandom_range(0, TO + 1);
            rdy_always = (wait_n == 0) && ($urandom_range(0, 1) == 1);
            run_batch(mask);
            pend = mask;
            n = $countones(mask);
            for (int k = 0; k < n; k++) begin
                p = rr_pick(pend, m_last);
                model_apply(b_w[p], b_a[p], b_d[p], eff_wait(), erd, eer);
                vectors++;
                if (k >= obs_ack.size() || obs_ack[k] !== N'(1) << p || obs_rd[k] !== erd ||
                    obs_er[k] !== eer || obs_ps[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL random it%0d slot%0d: got %0d acks, want ack=%b rdata=%h err=%b psel=0",
                             it, k, obs_ack.size(), N'(1) << p, erd, eer);
                end
                m_last = p;
                pend = pend & ~(N'(1) << p);
            end
            vectors++;
            if (obs_ack.size() != n) begin
                miscompares++;
                $display("FAIL random_count it%0d: acks=%0d, want %0d", it, obs_ack.size(), n);
            end
        end
        rdy_always = 1'b0;
    endtask

    initial begin
        preset = 1'b1;
        req = '0;
        test_reset();
        test_contention();
        test_write_read();
        test_slverr();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
